ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage MIPS pipeline. It sits directly downstream of the forwarding unit and consumes its `ForwardingA`/`ForwardingB` selects. It muxes the forwarded operands, runs the ALU, and owns the EX/MEM pipeline register. It also holds an optional iterative multiplier with HI/LO registers, which raises a stall toward the hazard logic while it is busy.

## Interface
Parameters:
- `DATA_W`, default 32: datapath width.
- `REG_W`, default `` `LEN_INST_REG `` (5): register-index width.

Ports:
- `clk`  in  1: the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `ForwardingA`, `ForwardingB`  in  2: operand selects.
  - 00: ID/EX value.
  - 01: `MEM_WB_WriteData`.
  - 10: `EX_MEM_AluResult`.
  - 11: treated as 00.
- `ID_EX_RsData`, `ID_EX_RtData`, `ID_EX_Imm`  in  DATA_W: register-file and sign-extended immediate values.
- `ID_EX_Rd`  in  REG_W: destination register, already resolved rd/rt.
- `ID_EX_AluOp`  in  4: operation code from defs.v.
- `ID_EX_AluSrc`  in  1: selects `ID_EX_Imm` as operand B.
- `ID_EX_RegWrite`, `ID_EX_MemRead`, `ID_EX_MemWrite`, `ID_EX_MemToReg`  in  1 each: control bits.
- `MEM_WB_WriteData`  in  DATA_W: write-back value.
- `EX_MEM_AluResult`, `EX_MEM_StoreData`  out  DATA_W: registered results.
- `EX_MEM_Rd`  out  REG_W: registered destination.
- `EX_MEM_RegWrite`, `EX_MEM_MemRead`, `EX_MEM_MemWrite`, `EX_MEM_MemToReg`  out  1 each: registered control bits.
- `ExStall`  out  1: combinational. Freezes PC, IF/ID and ID/EX.

## Operation
- Operand selection:
  - `opA = fwd(ForwardingA, ID_EX_RsData)`.
  - `fwdB = fwd(ForwardingB, ID_EX_RtData)`.
  - `opB = ID_EX_AluSrc ? ID_EX_Imm : fwdB`.
  - Store data is always `fwdB`.
- ALU ops:
  - ADD and SUB wrap modulo 2^DATA_W; no overflow trap.
  - AND, OR, NOR.
  - SLT is signed; the result is 0 or 1, zero-extended.
  - Undefined codes produce result 0 with all write/mem controls forced to 0.
- EX/MEM register:
  - Each cycle it captures the ALU result, store data, rd and controls.
  - When `ExStall` = 1 it captures a bubble: all four control bits 0, data unchanged.
- Forwarding select 10 delivers the EX/MEM ALU result even when EX/MEM holds a load. Preventing load-use cases is the hazard unit's job.
- Multiplier (MULT signed, MULTU unsigned). Finite-state machine `IDLE` / `BUSY`:
  - **IDLE, MULT/MULTU in EX:**
    - Latch `opA` and `fwdB` in the sub-module; signed operands are converted to magnitudes plus a sign flag.
    - count ← 0, go to `BUSY`.
    - `ExStall` = 1.
  - **BUSY:**
    - One shift-add step per cycle.
    - `ExStall` = 1 while count ≠ 31.
  - **BUSY, count = 31:**
    - Final step, then negate if the sign flag is set.
    - Write the 64-bit product to {HI, LO}.
    - `ExStall` = 0, so the MULT retires into EX/MEM with RegWrite = 0.
    - Go to `IDLE`.
- Later forwarding changes do not affect an in-flight multiply, because the operands are latched.
- MFHI/MFLO return HI/LO through the normal ALU result path with the RegWrite passed in.

## Timing
- ALU ops: 1-cycle latency, EX → EX/MEM.
- MULT:
  - Occupies EX for 33 cycles.
  - `ExStall` is high for 32 consecutive cycles.
  - HI/LO are valid from the edge that retires the MULT, so an MFHI that immediately follows sees the new value.
- Reset:
  - All EX/MEM outputs are 0.
  - HI = LO = 0; state `IDLE`; count 0.
  - `ExStall` = 0 in the cycle after `rst` deasserts, unless a MULT is present.
- Reset mid-multiply aborts the multiply. HI/LO are cleared and the stall drops the next cycle.
- Back-to-back MULTs: the second starts in the cycle after the first retires. There is no idle gap other than that cycle.

## Configuration
- `MULT_EN` defined:
  - Multiplier sub-module, HI/LO and the state machine are present.
  - MULT, MULTU, MFHI and MFLO behave as above.
- `MULT_EN` undefined:
  - `ExStall` is tied to 0; no HI/LO storage.
  - MULT and MULTU retire with RegWrite = 0.
  - MFHI and MFLO return 0.

## Structure
- defs.v holds:
  - `` `LEN_INST_REG ``.
  - The ALU op codes: ADD 0, SUB 1, AND 2, OR 3, NOR 4, SLT 5, MULT 8, MULTU 9, MFHI 10, MFLO 11.
  - The forwarding select encodings.
- One sub-module, `mult_iter`:
  - Ports: start, signed flag, two operands.
  - Outputs: busy, done, and the 64-bit product.
- The `IDLE`/`BUSY` state machine and `ExStall` generation stay in `ex_stage`.

## Test plan
- **Forwarding A/B priority:**
  - Stimulus: ADD; RsData = 1, RtData = 2, MEM_WB_WriteData = 7, EX_MEM result from prior ADD = 5.
  - FwdA = 01, FwdB = 10 → EX_MEM_AluResult = 12.
  - FwdA = FwdB = 11 → EX_MEM_AluResult = 3.
- **SLT sign:** opA = 0xFFFFFFFF, opB = 1 → result 1. SLTU is not supported; ADD of the same operands → 0.
- **MULT signed:**
  - opA = −3, opB = 7.
  - `ExStall` high for exactly 32 cycles, with EX_MEM control bits 0 throughout.
  - Then MFHI → 0xFFFFFFFF and MFLO → 0xFFFFFFEB.
- **Operand latching:** change `ForwardingA` and `ID_EX_RsData` mid-BUSY → MULTU 0xFFFFFFFF × 2 gives HI = 1, LO = 0xFFFFFFFE.
- **Reset mid-multiply:** assert `rst` at BUSY count 10 → `ExStall` = 0, HI = LO = 0, all EX/MEM outputs 0 on the next edge.
- **MULT_EN undefined:** issue MULT → no stall, EX_MEM_RegWrite = 0; MFLO → 0.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared op codes, forwarding selects and control bundle for the MIPS execute stage.
package ex_stage_pkg;

    localparam int LEN_INST_REG = 5;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_MULT  = 4'd8;
    localparam logic [3:0] OP_MULTU = 4'd9;
    localparam logic [3:0] OP_MFHI  = 4'd10;
    localparam logic [3:0] OP_MFLO  = 4'd11;

    localparam logic [1:0] FWD_ID_EX  = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ex_ctrl_t;

    function automatic logic is_mult_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one bus.
interface ex_stage_if
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = LEN_INST_REG
);
    logic [DATA_W-1:0] ID_EX_RsData;
    logic [DATA_W-1:0] ID_EX_RtData;
    logic [DATA_W-1:0] ID_EX_Imm;
    logic [REG_W-1:0]  ID_EX_Rd;
    logic [3:0]        ID_EX_AluOp;
    logic              ID_EX_AluSrc;
    logic              ID_EX_RegWrite;
    logic              ID_EX_MemRead;
    logic              ID_EX_MemWrite;
    logic              ID_EX_MemToReg;

    logic [DATA_W-1:0] EX_MEM_AluResult;
    logic [DATA_W-1:0] EX_MEM_StoreData;
    logic [REG_W-1:0]  EX_MEM_Rd;
    logic              EX_MEM_RegWrite;
    logic              EX_MEM_MemRead;
    logic              EX_MEM_MemWrite;
    logic              EX_MEM_MemToReg;

    modport master (
        output ID_EX_RsData, ID_EX_RtData, ID_EX_Imm, ID_EX_Rd, ID_EX_AluOp, ID_EX_AluSrc,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg,
        input  EX_MEM_AluResult, EX_MEM_StoreData, EX_MEM_Rd,
               EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg
    );

    modport slave (
        input  ID_EX_RsData, ID_EX_RtData, ID_EX_Imm, ID_EX_Rd, ID_EX_AluOp, ID_EX_AluSrc,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg,
        output EX_MEM_AluResult, EX_MEM_StoreData, EX_MEM_Rd,
               EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg
    );
endinterface

// File: rtl/ex_stage_mult_iter.sv
// Iterative shift-add multiplier: one partial product per cycle on magnitudes,
// sign applied to the combinational product in the final (done) cycle.
module mult_iter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] mcand, acc, sum;
    logic [DATA_W-1:0]   mplier, a_mag, b_mag;
    logic                a_neg, b_neg, neg;

    assign a_neg = is_signed & op_a[DATA_W-1];
    assign b_neg = is_signed & op_b[DATA_W-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    assign sum     = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (cnt == CNT_W'(DATA_W-1));
    assign product = neg ? -sum : sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{DATA_W{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= a_neg ^ b_neg;
        end else if (busy) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, EX/MEM register and, with MULT_EN
// defined, an iterative multiplier with HI/LO that stalls the front end while busy.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = LEN_INST_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ForwardingA,
    input  logic [1:0]        ForwardingB,
    input  logic [DATA_W-1:0] MEM_WB_WriteData,
    output logic              ExStall,
    ex_stage_if.slave         bus
);
    ex_ctrl_t          ctrl_in, ctrl_ex;
    logic [DATA_W-1:0] op_a, fwd_b, op_b, alu_res, hi_val, lo_val;
    logic              ctrl_ok;

    assign ctrl_in = {bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemWrite, bus.ID_EX_MemToReg};

    // Select 11 falls through to the ID/EX value.
    always_comb begin
        case (ForwardingA)
            FWD_MEM_WB: op_a = MEM_WB_WriteData;
            FWD_EX_MEM: op_a = bus.EX_MEM_AluResult;
            default:    op_a = bus.ID_EX_RsData;
        endcase
        case (ForwardingB)
            FWD_MEM_WB: fwd_b = MEM_WB_WriteData;
            FWD_EX_MEM: fwd_b = bus.EX_MEM_AluResult;
            default:    fwd_b = bus.ID_EX_RtData;
        endcase
    end

    assign op_b = bus.ID_EX_AluSrc ? bus.ID_EX_Imm : fwd_b;

    always_comb begin
        alu_res = '0;
        ctrl_ok = 1'b1;
        case (bus.ID_EX_AluOp)
            OP_ADD:   alu_res = op_a + op_b;
            OP_SUB:   alu_res = op_a - op_b;
            OP_AND:   alu_res = op_a & op_b;
            OP_OR:    alu_res = op_a | op_b;
            OP_NOR:   alu_res = ~(op_a | op_b);
            OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_MULT,
            OP_MULTU: ctrl_ok = 1'b0;
            OP_MFHI:  alu_res = hi_val;
            OP_MFLO:  alu_res = lo_val;
            default:  ctrl_ok = 1'b0;
        endcase
    end

    assign ctrl_ex = ctrl_ok ? ctrl_in : '0;

`ifdef MULT_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]          state;
    logic                is_mult, m_start, m_busy, m_done;
    logic [2*DATA_W-1:0] m_prod;
    logic [DATA_W-1:0]   hi_q, lo_q;

    assign is_mult = is_mult_op(bus.ID_EX_AluOp);
    assign m_start = !rst && (state == ST_IDLE) && is_mult;

    mult_iter #(.DATA_W(DATA_W)) u_mult (
        .clk       (clk),
        .rst       (rst),
        .start     (m_start),
        .is_signed (bus.ID_EX_AluOp == OP_MULT),
        .op_a      (op_a),
        .op_b      (fwd_b),
        .busy      (m_busy),
        .done      (m_done),
        .product   (m_prod)
    );

    // HI/LO update on the retiring edge so a following MFHI/MFLO sees the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (m_start) state <= ST_BUSY;
                ST_BUSY: if (m_done || !m_busy) begin
                    state <= ST_IDLE;
                    if (m_done) {hi_q, lo_q} <= m_prod;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ExStall = ((state == ST_IDLE) && is_mult) || ((state == ST_BUSY) && !m_done);
    assign hi_val  = hi_q;
    assign lo_val  = lo_q;
`else
    assign ExStall = 1'b0;
    assign hi_val  = '0;
    assign lo_val  = '0;
`endif

    // A stall inserts a bubble: controls cleared, data held so EX/MEM forwarding stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.EX_MEM_AluResult <= '0;
            bus.EX_MEM_StoreData <= '0;
            bus.EX_MEM_Rd        <= '0;
            bus.EX_MEM_RegWrite  <= 1'b0;
            bus.EX_MEM_MemRead   <= 1'b0;
            bus.EX_MEM_MemWrite  <= 1'b0;
            bus.EX_MEM_MemToReg  <= 1'b0;
        end else if (ExStall) begin
            bus.EX_MEM_RegWrite  <= 1'b0;
            bus.EX_MEM_MemRead   <= 1'b0;
            bus.EX_MEM_MemWrite  <= 1'b0;
            bus.EX_MEM_MemToReg  <= 1'b0;
        end else begin
            bus.EX_MEM_AluResult <= alu_res;
            bus.EX_MEM_StoreData <= fwd_b;
            bus.EX_MEM_Rd        <= bus.ID_EX_Rd;
            bus.EX_MEM_RegWrite  <= ctrl_ex.reg_write;
            bus.EX_MEM_MemRead   <= ctrl_ex.mem_read;
            bus.EX_MEM_MemWrite  <= ctrl_ex.mem_write;
            bus.EX_MEM_MemToReg  <= ctrl_ex.mem_to_reg;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage; multiplier checks compile in when MULT_EN is defined.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
`ifdef MULT_EN
    localparam bit MULT_ON = 1'b1;
`else
    localparam bit MULT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    fa, fb;
    logic [DW-1:0] mwb;
    logic          ex_stall;

    ex_stage_if #(.DATA_W(DW), .REG_W(RW)) bus ();

    ex_stage #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk              (clk),
        .rst              (rst),
        .ForwardingA      (fa),
        .ForwardingB      (fb),
        .MEM_WB_WriteData (mwb),
        .ExStall          (ex_stall),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] res;
        logic [DW-1:0] sd;
        logic [RW-1:0] rd;
        logic [3:0]    ctrl;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    // Architectural model state: last retired ALU result and HI/LO.
    logic [DW-1:0] m_exmem = '0, m_hi = '0, m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] out_ctrl();
        return {bus.EX_MEM_RegWrite, bus.EX_MEM_MemRead, bus.EX_MEM_MemWrite, bus.EX_MEM_MemToReg};
    endfunction

    function automatic logic [DW-1:0] fwdv(input logic [1:0] s, input logic [DW-1:0] v,
                                           input logic [DW-1:0] w);
        case (s)
            2'b01:   return w;
            2'b10:   return m_exmem;
            default: return v;
        endcase
    endfunction

    // Monitor: each edge either retires the oldest expected instruction or is a bubble.
    initial begin : monitor
        exp_t e, last;
        bit   st;
        last = '{default: '0};
        forever begin
            @(negedge clk);
            st = ex_stall;
            @(posedge clk);
            #2;
            if (!mon_en) begin
                last = '{default: '0};
            end else if (q.size() > 0) begin
                e = q.pop_front();
                check("res",  bus.EX_MEM_AluResult, e.res);
                check("sd",   bus.EX_MEM_StoreData, e.sd);
                check("rd",   bus.EX_MEM_Rd, e.rd);
                check("ctrl", out_ctrl(), e.ctrl);
                last = e;
            end else if (st) begin
                check("bubble_ctrl", out_ctrl(), 4'b0000);
                check("bubble_res",  bus.EX_MEM_AluResult, last.res);
                check("bubble_sd",   bus.EX_MEM_StoreData, last.sd);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the instruction has retired.
    task automatic issue(input logic [3:0] op, input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                         input logic [DW-1:0] imm, input logic [RW-1:0] rd, input logic src,
                         input logic [3:0] ctrl, input logic [1:0] fa_i, input logic [1:0] fb_i,
                         input logic [DW-1:0] mwb_i, input bit wiggle);
        exp_t          e;
        logic [DW-1:0] a, b, ob;
        logic [63:0]   prod, ua, ub;
        int            n, exp_n;
        bus.ID_EX_AluOp  = op;
        bus.ID_EX_RsData = rs;
        bus.ID_EX_RtData = rt;
        bus.ID_EX_Imm    = imm;
        bus.ID_EX_Rd     = rd;
        bus.ID_EX_AluSrc = src;
        {bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemWrite, bus.ID_EX_MemToReg} = ctrl;
        fa  = fa_i;
        fb  = fb_i;
        mwb = mwb_i;

        a  = fwdv(fa_i, rs, mwb_i);
        b  = fwdv(fb_i, rt, mwb_i);
        ob = src ? imm : b;
        e.sd   = b;
        e.rd   = rd;
        e.ctrl = ctrl;
        e.res  = '0;
        prod   = '0;
        exp_n  = 0;
        case (op)
            OP_ADD:  e.res = a + ob;
            OP_SUB:  e.res = a - ob;
            OP_AND:  e.res = a & ob;
            OP_OR:   e.res = a | ob;
            OP_NOR:  e.res = ~(a | ob);
            OP_SLT:  e.res = ($signed(a) < $signed(ob)) ? 32'd1 : 32'd0;
            OP_MFHI: e.res = m_hi;
            OP_MFLO: e.res = m_lo;
            OP_MULT: begin
                prod   = 64'(longint'($signed(a)) * longint'($signed(b)));
                e.ctrl = 4'b0000;
                exp_n  = MULT_ON ? 32 : 0;
            end
            OP_MULTU: begin
                ua = {32'b0, a};
                ub = {32'b0, b};
                prod   = ua * ub;
                e.ctrl = 4'b0000;
                exp_n  = MULT_ON ? 32 : 0;
            end
            default: e.ctrl = 4'b0000;
        endcase

        n = 0;
        forever begin
            @(negedge clk);
            if (!ex_stall) break;
            n++;
            if (n > 40) begin
                $display("FAIL stall_timeout actual=%0d required=%0d", n, exp_n);
                break;
            end
            if (wiggle && n == 6) begin
                fa = 2'b01;
                bus.ID_EX_RsData = ~rs;
            end
            @(posedge clk);
        end
        check("stall_cycles", 64'(n), 64'(exp_n));
        q.push_back(e);
        @(posedge clk);
        #1;
        m_exmem = e.res;
        if (MULT_ON && is_mult_op(op)) {m_hi, m_lo} = prod;
    endtask

    task automatic rand_issue();
        logic [3:0] op, ctrl;
        op   = 4'($urandom_range(0, 15));
        ctrl = 4'($urandom_range(0, 15));
        if (is_mult_op(op)) ctrl = {ctrl[3], 3'b000};
        issue(op, $urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom,
              5'($urandom), 1'($urandom), ctrl, 2'($urandom), 2'($urandom), $urandom, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        fa = 2'b00; fb = 2'b00; mwb = '0;
        bus.ID_EX_AluOp = OP_ADD; bus.ID_EX_RsData = '0; bus.ID_EX_RtData = '0;
        bus.ID_EX_Imm = '0; bus.ID_EX_Rd = '0; bus.ID_EX_AluSrc = 1'b0;
        bus.ID_EX_RegWrite = 1'b0; bus.ID_EX_MemRead = 1'b0;
        bus.ID_EX_MemWrite = 1'b0; bus.ID_EX_MemToReg = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res",   bus.EX_MEM_AluResult, 0);
        check("rst_sd",    bus.EX_MEM_StoreData, 0);
        check("rst_rd",    bus.EX_MEM_Rd, 0);
        check("rst_ctrl",  out_ctrl(), 0);
        check("rst_stall", ex_stall, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Forwarding priority: prior ADD leaves 5 in EX/MEM.
        issue(OP_ADD, 32'd2, 32'd3, 0, 5'd1, 1'b0, 4'b1000, 2'b00, 2'b00, 32'd0, 1'b0);
        issue(OP_ADD, 32'd1, 32'd2, 0, 5'd2, 1'b0, 4'b1000, 2'b01, 2'b10, 32'd7, 1'b0);
        issue(OP_ADD, 32'd1, 32'd2, 0, 5'd3, 1'b0, 4'b1000, 2'b11, 2'b11, 32'd7, 1'b0);
        // SLT signed versus wrapping ADD of the same operands.
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 0, 5'd4, 1'b0, 4'b1000, 2'b00, 2'b00, 0, 1'b0);
        issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, 0, 5'd5, 1'b0, 4'b1000, 2'b00, 2'b00, 0, 1'b0);
        issue(OP_SUB, 32'd0, 32'd1, 0, 5'd6, 1'b0, 4'b1000, 2'b00, 2'b00, 0, 1'b0);
        issue(OP_NOR, 32'h0F0F_0000, 32'h0000_00FF, 0, 5'd7, 1'b0, 4'b1000, 2'b00, 2'b00, 0, 1'b0);
        issue(OP_OR, 32'h10, 32'h1, 32'h0100_0000, 5'd8, 1'b1, 4'b0110, 2'b00, 2'b00, 0, 1'b0);
        issue(4'd6, 32'd9, 32'd9, 0, 5'd9, 1'b0, 4'b1111, 2'b00, 2'b00, 0, 1'b0);
        issue(4'd15, 32'd9, 32'd9, 0, 5'd10, 1'b0, 4'b1111, 2'b10, 2'b01, 32'd3, 1'b0);

        // Signed multiply, then read HI/LO back through the ALU path.
        issue(OP_MULT, -32'sd3, 32'd7, 0, 5'd11, 1'b0, 4'b1000, 2'b00, 2'b00, 0, 1'b0);
        issue(OP_MFHI, 0, 0, 0, 5'd12, 1'b0, 4'b1000, 2'b00, 2'b00, 0, 1'b0);
        issue(OP_MFLO, 0, 0, 0, 5'd13, 1'b0, 4'b1000, 2'b00, 2'b00, 0, 1'b0);
        // Unsigned multiply with operand inputs disturbed mid-flight.
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 5'd14, 1'b0, 4'b1000, 2'b00, 2'b00, 32'd55, 1'b1);
        issue(OP_MFHI, 0, 0, 0, 5'd15, 1'b0, 4'b1000, 2'b00, 2'b00, 0, 1'b0);
        issue(OP_MFLO, 0, 0, 0, 5'd16, 1'b0, 4'b1000, 2'b00, 2'b00, 0, 1'b0);
        // Back-to-back multiplies, including the most negative operand.
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 5'd17, 1'b0, 4'b1000, 2'b00, 2'b00, 0, 1'b0);
        issue(OP_MULT, 32'h8000_0000, 32'd5, 0, 5'd18, 1'b0, 4'b1000, 2'b00, 2'b10, 0, 1'b0);
        issue(OP_MFHI, 0, 0, 0, 5'd19, 1'b0, 4'b1000, 2'b00, 2'b00, 0, 1'b0);
        issue(OP_MFLO, 0, 0, 0, 5'd20, 1'b0, 4'b1000, 2'b00, 2'b00, 0, 1'b0);

        for (int i = 0; i < 200; i++) rand_issue();

`ifdef MULT_EN
        // Reset in the middle of a multiply (BUSY, count 10).
        #2;
        mon_en = 1'b0;
        bus.ID_EX_AluOp = OP_MULT;
        bus.ID_EX_RsData = 32'd1234;
        bus.ID_EX_RtData = 32'd77;
        fa = 2'b00; fb = 2'b00;
        repeat (11) @(posedge clk);
        #1;
        check("busy_before_rst", ex_stall, 1);
        rst = 1'b1;
        bus.ID_EX_AluOp = OP_ADD;
        @(posedge clk);
        #1;
        check("midrst_stall", ex_stall, 0);
        check("midrst_res",   bus.EX_MEM_AluResult, 0);
        check("midrst_sd",    bus.EX_MEM_StoreData, 0);
        check("midrst_rd",    bus.EX_MEM_Rd, 0);
        check("midrst_ctrl",  out_ctrl(), 0);
        rst = 1'b0;
        m_exmem = '0; m_hi = '0; m_lo = '0;
        #2;
        mon_en = 1'b1;
        issue(OP_MFHI, 0, 0, 0, 5'd21, 1'b0, 4'b1000, 2'b00, 2'b00, 0, 1'b0);
        issue(OP_MFLO, 0, 0, 0, 5'd22, 1'b0, 4'b1000, 2'b00, 2'b00, 0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #3;
        check("drain", 64'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
